// File: rtl/tcdm_resp_pkg.sv
// rtl/tcdm_resp_pkg.sv - shared defaults, LFSR constants and response record for the TCDM responder
package tcdm_resp_pkg;

  localparam int NB_PORTS_DEF   = 8;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int MEM_WORDS_DEF  = 64;
  localparam int PORT_W_DEF     = $clog2(NB_PORTS_DEF);

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps are bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_fb(input logic [7:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [PORT_W_DEF-1:0]     port;
    logic [DATA_WIDTH_DEF-1:0] data;
  } resp_t;

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// rtl/tcdm_rr_arbiter.sv - round-robin single grant, search ascending from i_ptr
module tcdm_rr_arbiter #(
  parameter int NB_PORTS = 8,
  localparam int PW      = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic [NB_PORTS-1:0] i_req,
  input  logic [PW-1:0]       i_ptr,
  input  logic                i_en,
  output logic [NB_PORTS-1:0] o_gnt,
  output logic [PW-1:0]       o_idx,
  output logic                o_valid
);

  logic [PW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NB_PORTS; i++) begin
      w_cand = PW'((int'(i_ptr) + i) % NB_PORTS);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/tcdm_lockstep_responder.sv
// rtl/tcdm_lockstep_responder.sv - single-ported TCDM responder, one grant per cycle, rvalid one cycle later
// Optional random grant stalls: define TCDM_RESP_STALL_EN.
module tcdm_lockstep_responder
  import tcdm_resp_pkg::*;
#(
  parameter int NB_PORTS   = NB_PORTS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_WORDS  = MEM_WORDS_DEF
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NB_PORTS-1:0]                  req_i,
  input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]  add_i,
  input  logic [NB_PORTS-1:0]                  wen_i,
  input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NB_PORTS-1:0]                  gnt_o,
  output logic [NB_PORTS-1:0]                  rvalid_o,
  output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o
);

  localparam int PW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = $clog2(MEM_WORDS);

  logic [PW-1:0]         r_rr_ptr;
  resp_t                 r_resp;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [NB_PORTS-1:0]   w_gnt;
  logic [PW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_stall;
  logic                  w_en;
  logic [IW-1:0]         w_word;
  logic                  w_unused_addr;

`ifdef TCDM_RESP_STALL_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {r_lfsr[6:0], lfsr_fb(r_lfsr)};
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Reset gates the grant combinationally so nothing is accepted while held.
  assign w_en = rst_ni & ~w_stall;

  tcdm_rr_arbiter #(.NB_PORTS(NB_PORTS)) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign gnt_o         = w_gnt;
  assign w_word        = add_i[w_idx][2 +: IW];
  assign w_unused_addr = ^add_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_idx == PW'(NB_PORTS - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_any && !wen_i[w_idx]) begin
      for (int b = 0; b < BW; b++) begin
        if (be_i[w_idx][b]) r_mem[w_word][8*b +: 8] <= wdata_i[w_idx][8*b +: 8];
      end
    end
  end

  // Writes respond too, with zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp <= '0;
    end else if (w_any) begin
      r_resp.valid <= 1'b1;
      r_resp.port  <= PORT_W_DEF'(w_idx);
      r_resp.data  <= wen_i[w_idx] ? DATA_WIDTH_DEF'(r_mem[w_word]) : '0;
    end else begin
      r_resp.valid <= 1'b0;
    end
  end

  always_comb begin
    rvalid_o                     = '0;
    rvalid_o[PW'(r_resp.port)]   = r_resp.valid;
  end

  assign rdata_o = {NB_PORTS{DATA_WIDTH'(r_resp.data)}};

endmodule

// File: tb/tb_tcdm_lockstep_responder.sv
// tb/tb_tcdm_lockstep_responder.sv - directed table-driven bench for tcdm_lockstep_responder
module tb_tcdm_lockstep_responder;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic [N-1:0]              req_i;
  logic [N-1:0][AW-1:0]      add_i;
  logic [N-1:0]              wen_i;
  logic [N-1:0][BW-1:0]      be_i;
  logic [N-1:0][DW-1:0]      wdata_i;
  logic [N-1:0]              gnt_o;
  logic [N-1:0]              rvalid_o;
  logic [N-1:0][DW-1:0]      rdata_o;

  int checks = 0;
  int errors = 0;

  tcdm_lockstep_responder dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .add_i    (add_i),
    .wen_i    (wen_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    req_i = '0; add_i = '0; wen_i = '0; be_i = '0; wdata_i = '0;
  endtask

  task automatic drive(input int p, input logic wen, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    req_i[p] = 1'b1; wen_i[p] = wen; add_i[p] = addr; be_i[p] = be; wdata_i[p] = wdata;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[v.port] = 1'b1;
    clear_all();
    drive(v.port, v.wen, v.addr, v.be, v.wdata);
    n = 0;
    @(negedge clk);
    while (gnt_o == '0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " gnt"}, N*DW'(gnt_o), N*DW'(onehot));
    @(posedge clk); #1;
    clear_all();
    @(negedge clk);
    chk({tag, " rvalid"}, N*DW'(rvalid_o), N*DW'(onehot));
    chk({tag, " rdata"}, rdata_o, {N{v.exp}});
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{3, 1'b0, 32'h10,   4'hF,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{3, 1'b1, 32'h10,   4'h0,    32'h0,        32'hDEADBEEF};
    vecs[2] = '{5, 1'b0, 32'h10,   4'b0011, 32'h11223344, 32'h0};
    vecs[3] = '{5, 1'b1, 32'h10,   4'h0,    32'h0,        32'hDEAD3344};
    vecs[4] = '{1, 1'b1, 32'h110,  4'h0,    32'h0,        32'hDEAD3344};
    vecs[5] = '{7, 1'b0, 32'hFC,   4'b1100, 32'hAABBCCDD, 32'h0};
    vecs[6] = '{0, 1'b1, 32'hFC,   4'h0,    32'h0,        32'hAABB0000};
    vecs[7] = '{2, 1'b1, 32'h0,    4'h0,    32'h0,        32'h0};
    vecs[8] = '{6, 1'b0, 32'h4,    4'b1001, 32'h12345678, 32'h0};
    vecs[9] = '{4, 1'b1, 32'h1004, 4'h0,    32'h0,        32'h12000078};

    rst_ni = 1'b0;
    clear_all();
    req_i = '1;
    wen_i = '1;
    repeat (3) @(negedge clk);
    chk("reset gnt", N*DW'(gnt_o), '0);
    chk("reset rvalid", N*DW'(rvalid_o), '0);
    chk("reset rdata", rdata_o, '0);

`ifdef TCDM_RESP_STALL_EN
    clear_all();
    drive(0, 1'b1, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("stall cycle0 gnt", N*DW'(gnt_o), '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall cycle1 gnt", N*DW'(gnt_o), N*DW'(8'h01));
    @(posedge clk); #1 clear_all();
    @(negedge clk);
    chk("stall cycle2 rvalid", N*DW'(rvalid_o), N*DW'(8'h01));
    @(posedge clk); #1;
`else
    @(posedge clk); #1 rst_ni = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("contend c%0d gnt", k), N*DW'(gnt_o),
          (k < 8) ? N*DW'(1) << k : '0);
      chk($sformatf("contend c%0d rvalid", k), N*DW'(rvalid_o),
          (k > 0) ? N*DW'(1) << (k - 1) : '0);
      @(posedge clk); #1;
      if (k < 8) req_i[k] = 1'b0;
    end

    clear_all();
    drive(0, 1'b1, 32'h0, 4'h0, 32'h0);
    drive(5, 1'b1, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("ptr wrap gnt0", N*DW'(gnt_o), N*DW'(8'h01));
    @(posedge clk); #1 req_i[0] = 1'b0;
    @(negedge clk);
    chk("ptr wrap gnt5", N*DW'(gnt_o), N*DW'(8'h20));
    @(posedge clk); #1 clear_all();

    drive(3, 1'b0, 32'h28, 4'hF, 32'hCAFEF00D);
    drive(4, 1'b1, 32'h28, 4'h0, 32'h0);
    @(negedge clk);
    chk("raw gnt3", N*DW'(gnt_o), N*DW'(8'h08));
    @(posedge clk); #1 req_i[3] = 1'b0;
    @(negedge clk);
    chk("raw gnt4", N*DW'(gnt_o), N*DW'(8'h10));
    chk("raw rvalid3", N*DW'(rvalid_o), N*DW'(8'h08));
    chk("raw rdata3", rdata_o, '0);
    @(posedge clk); #1 clear_all();
    @(negedge clk);
    chk("raw rvalid4", N*DW'(rvalid_o), N*DW'(8'h10));
    chk("raw rdata4", rdata_o, {N{32'hCAFEF00D}});
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    begin
      int n;
      clear_all();
      drive(2, 1'b1, 32'h10, 4'h0, 32'h0);
      n = 0;
      @(negedge clk);
      while (gnt_o == '0 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("rstmid gnt", N*DW'(gnt_o), N*DW'(8'h04));
      @(posedge clk); #1 clear_all();
      chk("rstmid rvalid before", N*DW'(rvalid_o), N*DW'(8'h04));
      #2 rst_ni = 1'b0;
      #1;
      chk("rstmid rvalid async", N*DW'(rvalid_o), '0);
      chk("rstmid rdata async", rdata_o, '0);
      @(posedge clk); #1 rst_ni = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("rstmid quiet%0d", k), N*DW'(rvalid_o), '0);
      end
      @(posedge clk); #1;
    end

    run_vec('{2, 1'b1, 32'h10, 4'h0, 32'h0, 32'h0}, "memclr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
